angle_track_unwrap: RTL and testbench

Downstream consumer of `cordic_angle_calc`. It takes the first-quadrant angle (`theta_1st_quad`, 2^-15 rad LSB) and the quadrant index. From these it:
- rebuilds a full-circle binary angle (65536 counts per turn),
- unwraps it into a 32-bit multi-turn position,
- derives a per-sample angle delta and a moving-average speed.

It feeds the position and speed consumers of the angle-sensing path.

---
 rtl/angle_track_unwrap.sv | 136 +++++++++++++
 tb/tb_angle_track_unwrap.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_track_unwrap.sv
// angle_track_unwrap: rebuilds a full-circle binary angle from a first-quadrant
// CORDIC angle plus quadrant index, unwraps it into a 32-bit multi-turn position
// and produces a per-sample delta and a moving-average speed.
// Pipeline: S1 scale, S2 round/saturate/merge quadrant, S3 unwrap/average/output.
module angle_track_unwrap #(
  parameter int AVG_LOG2 = 3,
  parameter int K_TURN   = 20861
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [16:0] theta_in,
  input  logic        [1:0]  quad_in,
  output logic               out_valid,
  output logic        [15:0] angle_out,
  output logic signed [15:0] turns_out,
  output logic signed [15:0] delta_out,
  output logic signed [15:0] speed_avg
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = 16 + AVG_LOG2;
  localparam logic [32:0] K_W = 33'(K_TURN);

  // S1 state
  logic        v1_r;
  logic [32:0] prod_r;
  logic [1:0]  quad1_r;
  // S2 state
  logic        v2_r;
  logic [15:0] ang_r;
  // S3 state
  logic                 first_r;
  logic [15:0]          prev_ang_r;
  logic [31:0]          pos_r;
  logic signed [SW-1:0] sum_r;
  logic signed [15:0]   win_r [WIN];

  logic [15:0]          theta_c_s;
  logic [32:0]          prod_s;
  logic [16:0]          frac_raw_s;
  logic [13:0]          frac_s;
  logic [15:0]          ang_s;
  logic [15:0]          diff_s;
  logic signed [15:0]   delta_s;
  logic [31:0]          pos_next_s;
  logic signed [SW-1:0] sum_next_s;
  logic signed [15:0]   speed_s;

  // S1 arithmetic: clamp negative angles to zero and scale rad to turn units
  always_comb begin
    theta_c_s = theta_in[16] ? 16'd0 : theta_in[15:0];
    prod_s    = {17'd0, theta_c_s} * K_W;
  end

  // S1 register: capture product and quadrant on valid tokens only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      prod_r  <= 33'd0;
      quad1_r <= 2'd0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        prod_r  <= prod_s;
        quad1_r <= quad_in;
      end
    end
  end

  // S2 arithmetic: round to turn LSB, keep inside one quadrant, add quadrant base
  always_comb begin
    frac_raw_s = 17'((prod_r + 33'd32768) >> 16);
    frac_s     = (frac_raw_s > 17'd16383) ? 14'h3FFF : frac_raw_s[13:0];
    ang_s      = {quad1_r, 14'd0} + {2'b00, frac_s};
  end

  // S2 register: full-circle angle for the valid token
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r  <= 1'b0;
      ang_r <= 16'd0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        ang_r <= ang_s;
      end
    end
  end

  // S3 arithmetic: shortest-path delta, position update and window sum
  always_comb begin
    diff_s     = ang_r - prev_ang_r;
    delta_s    = first_r ? 16'sd0 : signed'(diff_s);
    pos_next_s = first_r ? {16'h0000, ang_r}
                         : pos_r + {{16{delta_s[15]}}, delta_s};
    sum_next_s = sum_r + signed'({{AVG_LOG2{delta_s[15]}}, delta_s})
                       - signed'({{AVG_LOG2{win_r[WIN-1][15]}}, win_r[WIN-1]});
    speed_s    = 16'(sum_next_s >>> AVG_LOG2);
  end

  // S3 register: unwrap state, averaging window and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_r    <= 1'b1;
      prev_ang_r <= 16'd0;
      pos_r      <= 32'd0;
      sum_r      <= '0;
      for (int i = 0; i < WIN; i++) begin
        win_r[i] <= 16'sd0;
      end
      out_valid  <= 1'b0;
      angle_out  <= 16'd0;
      turns_out  <= 16'sd0;
      delta_out  <= 16'sd0;
      speed_avg  <= 16'sd0;
    end else begin
      out_valid <= v2_r;
      if (v2_r) begin
        first_r    <= 1'b0;
        prev_ang_r <= ang_r;
        pos_r      <= pos_next_s;
        sum_r      <= sum_next_s;
        win_r[0]   <= delta_s;
        for (int i = 1; i < WIN; i++) begin
          win_r[i] <= win_r[i-1];
        end
        angle_out  <= pos_next_s[15:0];
        turns_out  <= signed'(pos_next_s[31:16]);
        delta_out  <= delta_s;
        speed_avg  <= speed_s;
      end
    end
  end

endmodule

// File: tb/tb_angle_track_unwrap.sv
// Self-checking bench for angle_track_unwrap: directed steps push expected
// results into a scoreboard; a monitor pops and compares on each out_valid.
module tb_angle_track_unwrap;

  localparam int AVG_LOG2 = 3;
  localparam int K_TURN   = 20861;
  localparam int WIN      = 8;
  localparam int NONE     = -1000000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [16:0] theta_in = 17'sd0;
  logic        [1:0]  quad_in = 2'd0;
  logic               out_valid;
  logic        [15:0] angle_out;
  logic signed [15:0] turns_out;
  logic signed [15:0] delta_out;
  logic signed [15:0] speed_avg;

  angle_track_unwrap #(.AVG_LOG2(AVG_LOG2), .K_TURN(K_TURN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .theta_in(theta_in),
    .quad_in(quad_in), .out_valid(out_valid), .angle_out(angle_out),
    .turns_out(turns_out), .delta_out(delta_out), .speed_avg(speed_avg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] angle;
    logic [15:0] turns;
    logic [15:0] delta;
    logic [15:0] speed;
    int          cyc;
    int          la;
    int          ld;
    int          ls;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state
  int          m_prev;
  logic [31:0] m_pos;
  bit          m_first;
  int          m_win[WIN];
  int          m_sum;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 0;
    m_pos   = 32'd0;
    m_first = 1'b1;
    m_sum   = 0;
    for (int i = 0; i < WIN; i++) m_win[i] = 0;
  endtask

  function automatic int theta_for(input int f);
    if (f == 0) return 0;
    return (f * 65536 - 32768 + K_TURN - 1) / K_TURN;
  endfunction

  // drive one sample, model its result and push the expectation
  task automatic send(input int q, input int th, input int la, input int ld, input int ls);
    exp_t   e;
    int     thc;
    longint p;
    int     frac;
    int     ang;
    int     d;
    int     sp;
    thc  = (th < 0) ? 0 : th;
    p    = longint'(thc) * longint'(K_TURN);
    frac = int'((p + 64'sd32768) / 64'sd65536);
    if (frac > 16383) frac = 16383;
    ang  = (q * 16384 + frac) % 65536;
    if (m_first) begin
      d       = 0;
      m_pos   = {16'd0, 16'(ang)};
      m_first = 1'b0;
    end else begin
      d = ang - m_prev;
      if (d > 32767) d -= 65536;
      else if (d < -32768) d += 65536;
      m_pos = m_pos + 32'(d);
    end
    m_prev = ang;
    m_sum  = m_sum + d - m_win[WIN-1];
    for (int i = WIN - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = d;
    if (m_sum >= 0) sp = m_sum / WIN;
    else sp = -((-m_sum + WIN - 1) / WIN);
    e.angle = 16'(ang);
    e.turns = m_pos[31:16];
    e.delta = 16'(d);
    e.speed = 16'(sp);
    e.cyc   = cyc;
    e.la    = la;
    e.ld    = ld;
    e.ls    = ls;
    sb.push_back(e);
    in_valid = 1'b1;
    quad_in  = 2'(q);
    theta_in = 17'(th);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // assert reset with random input activity, discard in-flight expectations
  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    model_reset();
    repeat (4) begin
      in_valid = 1'($urandom_range(0, 1));
      theta_in = 17'($urandom);
      quad_in  = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    idle(1);
  endtask

  // monitor: reset values, scoreboard compare on strobe, hold between strobes
  always @(negedge clk) begin
    if (!rst) begin
      chk16("rst_valid", {15'd0, out_valid}, 16'd0);
      chk16("rst_angle", angle_out, 16'd0);
      chk16("rst_turns", turns_out, 16'd0);
      chk16("rst_delta", delta_out, 16'd0);
      chk16("rst_speed", speed_avg, 16'd0);
      last.angle = 16'd0;
      last.turns = 16'd0;
      last.delta = 16'd0;
      last.speed = 16'd0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk16("spurious_valid", {15'd0, out_valid}, 16'd0);
      end else begin
        mon_e = sb.pop_front();
        chki("latency", cyc - mon_e.cyc, 3);
        chk16("angle", angle_out, mon_e.angle);
        chk16("turns", turns_out, mon_e.turns);
        chk16("delta", delta_out, mon_e.delta);
        chk16("speed", speed_avg, mon_e.speed);
        if (mon_e.la != NONE) chk16("lit_angle", angle_out, 16'(mon_e.la));
        if (mon_e.ld != NONE) chk16("lit_delta", delta_out, 16'(mon_e.ld));
        if (mon_e.ls != NONE) chk16("lit_speed", speed_avg, 16'(mon_e.ls));
        last = mon_e;
      end
    end else begin
      chk16("hold_angle", angle_out, last.angle);
      chk16("hold_turns", turns_out, last.turns);
      chk16("hold_delta", delta_out, last.delta);
      chk16("hold_speed", speed_avg, last.speed);
    end
  end

  int sp_tab[12] = '{12, 25, 37, 50, 62, 75, 87, 100, 100, 100, 100, 100};

  initial begin
    #1;
    // reset with toggling inputs, then a zero sample
    do_reset();
    send(0, 0, 0, 0, 0);
    idle(4);

    // quadrant mapping from a fresh start
    do_reset();
    send(1, 25736, 24576, 0, NONE);
    send(2, 0, 32768, 8192, NONE);
    send(3, 51472, 65535, 32767, NONE);
    idle(4);

    // forward wrap: 65000 -> 500 crosses into the next turn
    send(3, 49787, 65000, NONE, NONE);
    send(0, 1571, 500, 1036, NONE);
    idle(4);

    // reverse wrap: 500 -> 65000 goes back one turn
    do_reset();
    send(0, 1571, 500, 0, NONE);
    send(3, 49787, 65000, -1036, NONE);
    idle(4);

    // negative clamp and over-range saturation
    do_reset();
    send(0, -5, 0, 0, NONE);
    send(1, 60000, 32767, 32767, NONE);
    idle(4);

    // constant +100 step with input gaps, window ramp
    do_reset();
    send(0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      send(0, theta_for(100 * k), 100 * k, 100, sp_tab[k-1]);
      idle(k % 3);
    end
    idle(4);

    // reset with tokens in flight, then first-sample rule again
    send(0, theta_for(1300), NONE, NONE, NONE);
    send(0, theta_for(1400), NONE, NONE, NONE);
    send(0, theta_for(1500), NONE, NONE, NONE);
    do_reset();
    send(0, theta_for(300), 300, 0, 0);
    idle(4);

    // random back-to-back traffic against the model
    for (int i = 0; i < 30; i++) begin
      send($urandom_range(0, 3), $urandom_range(0, 65635) - 100, NONE, NONE, NONE);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    #6;
    chki("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
